bin_to_seg_encoder: RTL and testbench

//  Converts an unsigned binary value into the packed per-digit cathode vector consumed by
//  the multiplexed 7-segment scan driver (8 bits per digit, digit 0 = rightmost).

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg7_digit_decode.sv | 18 +
 rtl/bin_to_seg_encoder.sv | 153 +++++++++++++++
 tb/tb_bin_to_seg_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-7-segment encoder.
//   seg_t       : one digit pattern, bit order {DP,G,F,E,D,C,B,A}, active-low
//   SEG_DIGIT   : patterns for decimal digits 0..9
//   state_t     : encoder FSM states
//   pow10       : elaboration-time power of ten for the overflow bound
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK   = 8'hFF;
  localparam seg_t SEG_DASH    = 8'hBF;
  localparam seg_t SEG_DP_MASK = 8'h7F;

  localparam seg_t SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_ENCODE
  } state_t;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned k = 0; k < n; k++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD nibble to 7-segment pattern decoder.
//   nibble : 4-bit BCD digit
//   seg    : active-low pattern; non-decimal nibbles show a dash
module seg7_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (nibble <= 4'd9) begin
      seg = SEG_DIGIT[nibble];
    end
  end

endmodule

// File: rtl/bin_to_seg_encoder.sv
// Iterative double-dabble binary to packed 7-segment encoder.
//   clk, rst  : clock, asynchronous active-low reset
//   in_valid  : request, accepted when in_valid && in_ready
//   in_ready  : idle, able to accept
//   in_data   : unsigned value to display
//   in_dp     : per-digit decimal point enables
//   blank_lz  : blank leading zeros
//   busy      : conversion in progress
//   done      : one-cycle pulse, display updated on the same edge
//   display   : packed patterns, digit i at [i*8+:8]
module bin_to_seg_encoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BIN_WIDTH  = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_WIDTH-1:0]    in_data,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*8-1:0] display
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [BIN_WIDTH+3:0] MAX_VAL = (BIN_WIDTH + 4)'(pow10(NUM_DIGITS) - 64'd1);

  state_t state, state_next;

  logic [BCD_W-1:0]      bcd, bcd_adj;
  logic [BIN_WIDTH-1:0]  bin;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_DIGITS-1:0] dp_q;
  logic                  blz_q;
  logic                  ovf;
  logic                  accept;
  logic                  last_iter;

  seg_t                  dec [NUM_DIGITS];
  logic [NUM_DIGITS*8-1:0] disp_next;
  logic                  upper_zero;
  logic                  dp_seen;
  seg_t                  pat;

  assign accept    = in_valid && (state == ST_IDLE);
  assign last_iter = (cnt == CNT_W'(BIN_WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (in_valid)  state_next = ST_CONVERT;
      ST_CONVERT: if (last_iter) state_next = ST_ENCODE;
      ST_ENCODE:                 state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

  // Add-3 correction applied before every shift
  always_comb begin
    bcd_adj = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      bcd_adj[d*4+:4] = (bcd[d*4+:4] >= 4'd5) ? bcd[d*4+:4] + 4'd3 : bcd[d*4+:4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd   <= '0;
      bin   <= '0;
      cnt   <= '0;
      dp_q  <= '0;
      blz_q <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      bcd   <= '0;
      bin   <= in_data;
      cnt   <= '0;
      dp_q  <= in_dp;
      blz_q <= blank_lz;
      ovf   <= ({4'b0000, in_data} > MAX_VAL);
    end else if (state == ST_CONVERT) begin
      bcd <= {bcd_adj[BCD_W-2:0], bin[BIN_WIDTH-1]};
      bin <= bin << 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_digit_decode u_dec (
      .nibble (bcd[g*4+:4]),
      .seg    (dec[g])
    );
  end

  // Scan from the most significant digit down so the "all higher digits zero"
  // and "a DP at or above this digit" conditions accumulate in one pass.
  always_comb begin
    disp_next  = '1;
    upper_zero = 1'b1;
    dp_seen    = 1'b0;
    pat        = SEG_BLANK;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      upper_zero = upper_zero && (bcd[(NUM_DIGITS-1-k)*4+:4] == 4'd0);
      dp_seen    = dp_seen || dp_q[NUM_DIGITS-1-k];
      if (ovf) begin
        pat = SEG_DASH;
      end else if (blz_q && (k != NUM_DIGITS - 1) && upper_zero && !dp_seen) begin
        pat = SEG_BLANK;
      end else begin
        pat = dec[NUM_DIGITS-1-k];
      end
      if (dp_q[NUM_DIGITS-1-k]) begin
        pat = pat & SEG_DP_MASK;
      end
      disp_next[(NUM_DIGITS-1-k)*8+:8] = pat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      display <= '1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_ENCODE) begin
        display <= disp_next;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_seg_encoder.sv
module tb_bin_to_seg_encoder;

  localparam int LATENCY = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_data = '0;
  logic [7:0]  in_dp = '0;
  logic        blank_lz = 1'b0;
  logic        busy;
  logic        done;
  logic [63:0] display;

  int checks = 0;
  int failures = 0;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  bin_to_seg_encoder #(.NUM_DIGITS(8), .BIN_WIDTH(27)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dp    (in_dp),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .display  (display)
  );

  // Reference: decimal digits by division, blanking from value magnitude.
  function automatic logic [63:0] model(input longint unsigned v, input logic [7:0] dp,
                                        input logic blz);
    logic [63:0] res;
    logic [7:0] pat;
    longint unsigned p;
    int hd;
    hd = -1;
    for (int i = 0; i < 8; i++) if (dp[i]) hd = i;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      if (v > 64'd99_999_999) begin
        pat = 8'hBF;
      end else begin
        pat = seg_tbl[int'((v / p) % 10)];
        if (blz && i > 0 && v < p && i > hd) pat = 8'hFF;
      end
      if (dp[i]) pat[7] = 1'b0;
      res[i*8+:8] = pat;
      p = p * 10;
    end
    return res;
  endfunction

  task automatic start(input logic [26:0] v, input logic [7:0] dp, input logic blz);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_ready: in_ready=%b expected 1", in_ready);
    end
    in_data = v; in_dp = dp; blank_lz = blz; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 27'($urandom); in_dp = 8'($urandom); blank_lz = 1'($urandom);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL after_accept: done=%b busy=%b expected done=0 busy=1", done, busy);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic finish_check(input string name, input int edges, input logic [26:0] v,
                              input logic [7:0] dp, input logic blz);
    logic [63:0] exp;
    exp = model(64'(v), dp, blz);
    checks++;
    if (edges != LATENCY) begin
      failures++;
      $display("FAIL %s_latency: edges=%0d expected %0d", name, edges, LATENCY);
    end
    checks++;
    if (display !== exp) begin
      failures++;
      $display("FAIL %s_display: got %h expected %h (v=%0d dp=%b blz=%b)",
               name, display, exp, v, dp, blz);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_ready_on_done: in_ready=%b busy=%b expected 1/0", name, in_ready, busy);
    end
  endtask

  task automatic run(input string name, input logic [26:0] v, input logic [7:0] dp,
                     input logic blz);
    int e;
    start(v, dp, blz);
    wait_done(e);
    finish_check(name, e, v, dp, blz);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (display !== {64{1'b1}} || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s: display=%h ready=%b busy=%b done=%b expected all-FF/1/0/0",
               name, display, in_ready, busy, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [63:0] exp;
    run("v1234", 27'd1234, 8'h00, 1'b1);
    exp = 64'hFFFF_FFFF_F9A4_B099;
    checks++;
    if (display !== exp) begin
      failures++;
      $display("FAIL v1234_literal: got %h expected %h", display, exp);
    end
    run("zero_blank", 27'd0, 8'h00, 1'b1);
    run("zero_noblank", 27'd0, 8'h00, 1'b0);
    run("five_dp2", 27'd5, 8'b0000_0100, 1'b1);
    exp = 64'hFFFF_FFFF_FF40_C092;
    checks++;
    if (display !== exp) begin
      failures++;
      $display("FAIL five_dp2_literal: got %h expected %h", display, exp);
    end
    run("overflow", 27'd100_000_000, 8'h00, 1'b1);
    run("max_legal", 27'd99_999_999, 8'h00, 1'b1);
    run("overflow_dp", 27'h7FF_FFFF, 8'h81, 1'b0);
  endtask

  task automatic test_busy_ignore;
    int e;
    start(27'd42, 8'h00, 1'b1);
    e = 0;
    while (e < 100) begin
      if (e == 9) begin
        in_valid = 1'b1; in_data = 27'd7; in_dp = 8'hFF; blank_lz = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      e++;
      if (e == 10) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ignore_busy: busy=%b ready=%b expected 1/0", busy, in_ready);
        end
      end
      if (done === 1'b1) break;
    end
    finish_check("ignore_mid", e, 27'd42, 8'h00, 1'b1);
  endtask

  task automatic test_reset_abort;
    int seen;
    start(27'd123, 8'h00, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || display !== {64{1'b1}}) begin
      failures++;
      $display("FAIL abort_no_done: done_pulses=%0d display=%h expected 0 / all-FF", seen, display);
    end
    run("after_abort", 27'd8_765_432, 8'h10, 1'b1);
  endtask

  task automatic test_random;
    logic [26:0] v;
    logic [7:0] dp;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: v = 27'($urandom_range(0, 999));
        1: v = 27'($urandom_range(0, 99_999_999));
        2: v = 27'($urandom_range(99_999_990, 100_000_010));
        default: v = 27'($urandom);
      endcase
      dp = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      run("random", v, dp, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    int e;
    logic [63:0] held;
    run("b2b_a", 27'd31_415_926, 8'h00, 1'b0);
    held = display;
    start(27'd27, 8'h02, 1'b1);
    e = 0;
    while (e < 100) begin
      @(posedge clk); #1;
      e++;
      if (done === 1'b1) break;
      if (e == 20) begin
        checks++;
        if (display !== held) begin
          failures++;
          $display("FAIL b2b_hold: got %h expected %h", display, held);
        end
      end
    end
    finish_check("b2b_b", e, 27'd27, 8'h02, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
